// File: rtl/buffered_async_operator.sv
// Elastic dataflow node: per-input FIFOs feed one op; the result is fanned out to every consumer.
// Define BUFFERED_OP_STATS_EN to add fire_count, stall_count and ovf_err outputs.
module buffered_async_operator #(
  parameter int    data_width  = 32,
  parameter string op          = "add",
  parameter int    immediate   = 0,
  parameter int    input_size  = 2,
  parameter int    output_size = 1,
  parameter int    depth       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [input_size-1:0]            req_l,
  input  logic [input_size-1:0]            ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic [output_size-1:0]           req_r,
  output logic [output_size-1:0]           ack_r,
  output logic [data_width-1:0]            dout
`ifdef BUFFERED_OP_STATS_EN
  ,
  output logic [31:0]                      fire_count,
  output logic [31:0]                      stall_count,
  output logic                             ovf_err
`endif
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL = (AW+1)'(depth);
  localparam logic [data_width-1:0] IMM = data_width'(immediate);

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_ADDI = 3;
  localparam int OP_SUBI = 4;
  localparam int OP_MULI = 5;
  localparam int OP_PASS = 6;
  localparam int OP_SEL  = (op == "add")  ? OP_ADD  :
                           (op == "sub")  ? OP_SUB  :
                           (op == "mul")  ? OP_MUL  :
                           (op == "addi") ? OP_ADDI :
                           (op == "subi") ? OP_SUBI :
                           (op == "muli") ? OP_MULI : OP_PASS;

  logic [data_width-1:0]  head [input_size];
  logic [input_size-1:0]  not_empty;
  logic                   all_ne;
  logic                   fire;
  logic [data_width-1:0]  result;
  logic [output_size-1:0] pend_q, pend_d;
  logic [output_size-1:0] ack_r_q, ack_r_d;
  logic [data_width-1:0]  dout_q, dout_d;
`ifdef BUFFERED_OP_STATS_EN
  logic [input_size-1:0]  full;
`endif

  for (genvar i = 0; i < input_size; i++) begin : g_fifo
    logic [data_width-1:0] mem_q [depth];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  req_q;

    always_comb begin
      cnt_d = cnt_q;
      if (ack_l[i] && !fire) begin
        cnt_d = cnt_q + 1'b1;
      end else if (fire && !ack_l[i]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        req_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (ack_l[i]) wptr_q <= wptr_q + 1'b1;
        if (fire)     rptr_q <= rptr_q + 1'b1;
        // request is withheld for the cycle after every ack, and while full
        req_q <= !ack_l[i] && (cnt_d < FULL);
      end
    end

    always_ff @(posedge clk) begin
      if (ack_l[i]) mem_q[wptr_q] <= din[i*data_width +: data_width];
    end

    assign head[i]      = mem_q[rptr_q];
    assign not_empty[i] = (cnt_q != '0);
    assign req_l[i]     = req_q;
`ifdef BUFFERED_OP_STATS_EN
    assign full[i]      = (cnt_q == FULL);
`endif
  end

  assign all_ne = &not_empty;
  assign fire   = all_ne && (pend_q == '0) && (ack_r_q == '0);

  always_comb begin
    result = head[0];
    case (OP_SEL)
      OP_ADD:  for (int k = 1; k < input_size; k++) result = result + head[k];
      OP_SUB:  for (int k = 1; k < input_size; k++) result = result - head[k];
      OP_MUL:  for (int k = 1; k < input_size; k++) result = result * head[k];
      OP_ADDI: result = head[0] + IMM;
      OP_SUBI: result = head[0] - IMM;
      OP_MULI: result = head[0] * IMM;
      default: result = head[0];
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    ack_r_d = '0;
    for (int j = 0; j < output_size; j++) begin
      if (pend_q[j] && req_r[j] && !ack_r_q[j]) begin
        ack_r_d[j] = 1'b1;
        pend_d[j]  = 1'b0;
      end
    end
    if (fire) pend_d = '1;
    dout_d = fire ? result : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      ack_r_q <= '0;
      dout_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      ack_r_q <= ack_r_d;
      dout_q  <= dout_d;
    end
  end

  assign ack_r = ack_r_q;
  assign dout  = dout_q;

`ifdef BUFFERED_OP_STATS_EN
  logic [31:0] fire_cnt_q, stall_cnt_q;
  logic        ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_cnt_q  <= '0;
      stall_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (fire)            fire_cnt_q  <= fire_cnt_q + 1'b1;
      if (all_ne && !fire) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (|(ack_l & full)) ovf_q       <= 1'b1;
    end
  end

  assign fire_count  = fire_cnt_q;
  assign stall_count = stall_cnt_q;
  assign ovf_err     = ovf_q;
`endif

endmodule
